// File: rtl/fifo_ptr_ctrl6_pkg.sv
// Shared sizing constants for the 6-entry FIFO pointer controller and its 6x8 buffer.
// Both the controller and the buffer take their default geometry from here.
package fifo_ptr_ctrl6_pkg;
    localparam int DATA_SIZE_DEF = 8;
    localparam int DEPTH_DEF     = 6;
    localparam int PTR_W_DEF     = 3;
    localparam int AF_TH_DEF     = 5;
    localparam int AE_TH_DEF     = 1;
endpackage

// File: rtl/fifo_ptr_ctrl6_mod_ptr_cnt.sv
// Modulo-DEPTH incrementing pointer with enable and synchronous active-low reset.
module mod_ptr_cnt
    import fifo_ptr_ctrl6_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = PTR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    // Wrap explicitly at DEPTH-1 so unused codes above it are never reached.
    always_comb begin
        ptr_next = ptr_reg;
        if (en) begin
            ptr_next = (ptr_reg == LAST) ? '0 : ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;
endmodule

// File: rtl/fifo_ptr_ctrl6.sv
// Pointer/flag controller for a 6-entry FIFO buffer (no data path).
// Define FIFO_PTR_CTRL_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_ptr_ctrl6
    import fifo_ptr_ctrl6_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PTR_W     = PTR_W_DEF,
    parameter int AF_TH     = AF_TH_DEF,
    parameter int AE_TH     = AE_TH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic             mem_write,
    output logic             mem_read,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [PTR_W-1:0] fill_count,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_TH);
    localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_TH);

    logic [PTR_W-1:0] count_reg;
    logic [PTR_W-1:0] count_next;
    logic             pop_ok;
    logic             push_ok;
    logic [1:0]       ptr_en;
    logic [PTR_W-1:0] ptr_val [2];

    // Flags decode registered occupancy only, keeping push/pop off the flag paths.
    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);
    assign fill_count   = count_reg;

    // No bypass: a pop on an empty buffer is refused even alongside a push.
    assign pop_ok    = pop & ~empty & reset;
    assign push_ok   = push & (~full | pop_ok) & reset;
    assign mem_read  = pop_ok;
    assign mem_write = push_ok;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + PTR_W'(1);
            2'b01:   count_next = count_reg - PTR_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Index 0 is the write pointer, index 1 the read pointer.
    assign ptr_en = {pop_ok, push_ok};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
            mod_ptr_cnt #(
                .DEPTH (DEPTH),
                .PTR_W (PTR_W)
            ) u_ptr (
                .clk   (clk),
                .reset (reset),
                .en    (ptr_en[gi]),
                .ptr   (ptr_val[gi])
            );
        end
    endgenerate

    assign wr_ptr = ptr_val[0];
    assign rd_ptr = ptr_val[1];

    logic [DATA_SIZE-1:0] unused_data;
    assign unused_data = '0;

`ifdef FIFO_PTR_CTRL_ERR_FLAGS_EN
    logic overflow_reg;
    logic overflow_next;
    logic underflow_reg;
    logic underflow_next;

    // A fresh error event wins over a same-cycle clear.
    always_comb begin
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (push & ~push_ok) begin
            overflow_next = 1'b1;
        end else if (err_clr) begin
            overflow_next = 1'b0;
        end
        if (pop & empty) begin
            underflow_next = 1'b1;
        end else if (err_clr) begin
            underflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif
endmodule

// File: doc/fifo_ptr_ctrl6.md
FIFO_PTR_CTRL6 -- requirements
Module: fifo_ptr_ctrl6

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, data width of the attached 6-entry buffer (informational; no data path in this block).
REQ-002 SHALL have parameter DEPTH, default 6, number of buffer entries.
REQ-003 SHALL have parameter PTR_W, default 3, pointer width.
REQ-004 SHALL have parameter AF_TH, default 5, almost-full threshold.
REQ-005 SHALL have parameter AE_TH, default 1, almost-empty threshold.
REQ-006 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-008 SHALL have ports push  input  1  write request, and pop  input  1  read request.
REQ-009 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-010 SHALL have ports mem_write  output  1  and mem_read  output  1, buffer write/read strobes.
REQ-011 SHALL have ports wr_ptr  output  PTR_W  and rd_ptr  output  PTR_W, buffer addresses.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty  output  1 each, status flags.
REQ-013 SHALL have port fill_count  output  PTR_W  occupied entries, 0..DEPTH.
REQ-014 SHALL have ports overflow  output  1  and underflow  output  1, sticky errors.

Function
REQ-015 SHALL drive mem_write = push & (~full | pop_ok) combinationally; write is accepted when not full, or when full and a pop is accepted in the same cycle.
REQ-016 SHALL drive mem_read = pop & ~empty combinationally (pop_ok); pop while empty is rejected even with a simultaneous push (no bypass).
REQ-017 SHALL advance wr_ptr on the edge ending a cycle with mem_write=1, and rd_ptr on the edge ending a cycle with mem_read=1; rd_ptr holds its value during the read cycle so the buffer returns the addressed word in the same cycle.
REQ-018 SHALL wrap each pointer from DEPTH-1 (5) to 0; values 6 and 7 are never produced.
REQ-019 SHALL update fill_count by +1 (write only), -1 (read only), or 0 (both or neither).
REQ-020 SHALL decode full = (fill_count==DEPTH), empty = (fill_count==0), almost_full = (fill_count>=AF_TH), almost_empty = (fill_count<=AE_TH), from registered state only; no combinational path from push/pop to flags.
REQ-021 SHALL set overflow on the edge after push=1 with mem_write=0, and underflow on the edge after pop=1 with empty=1; both hold until err_clr=1 or reset.
REQ-022 SHALL give a new error event priority over err_clr in the same cycle (flag stays set).

Reset
REQ-023 SHALL, while reset=0 at a rising edge, force wr_ptr=0, rd_ptr=0, fill_count=0, overflow=0, underflow=0; hence empty=1, almost_empty=1, full=0, almost_full=0.
REQ-024 SHALL gate mem_write and mem_read to 0 while reset=0; reset mid-operation discards all occupancy with no residual strobes.

Configuration
REQ-025 SHALL compile in overflow/underflow logic and err_clr use only when macro FIFO_PTR_CTRL_ERR_FLAGS_EN is defined; without it overflow and underflow are tied 0, err_clr is ignored, and all other behaviour is unchanged.

Structure
REQ-026 SHALL take DEPTH, PTR_W, AF_TH, AE_TH default constants from a shared include header used by both this block and the 6x8 buffer.
REQ-027 SHALL instantiate sub-module mod_ptr_cnt (modulo-DEPTH incrementing pointer with enable and synchronous active-low reset) twice, once per pointer.

Verification
REQ-028 Scenario: after reset, 6 pushes, no pops -> wr_ptr 0,1,2,3,4,5,0; fill_count 6; full=1 and almost_full=1 from count 5; rd_ptr=0.
REQ-029 Scenario: full, push=1 pop=0 -> mem_write=0, wr_ptr unchanged, overflow=1 next cycle; with FIFO_PTR_CTRL_ERR_FLAGS_EN undefined overflow stays 0.
REQ-030 Scenario: full, push=1 pop=1 -> mem_write=1, mem_read=1, both pointers advance, fill_count stays 6, no overflow.
REQ-031 Scenario: empty, push=1 pop=1 -> mem_read=0, mem_write=1, fill_count 1, underflow=1; err_clr=1 next cycle -> underflow=0.
REQ-032 Scenario: 9 push/pop pairs at count 2 -> pointers wrap 5->0, fill_count constant 2, almost_empty=0 throughout.
REQ-033 Scenario: fill to 4 then reset=0 for one cycle with push=1 -> mem_write=0, all pointers/count 0, empty=1 next cycle.
